// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide unit with architectural HI/LO registers.
// One shift-add (multiply) or restoring-division step per cycle on operand
// magnitudes; signs are reapplied in FIN. Flush aborts without touching HI/LO.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; MTHI/MTLO writes accepted here
// MUL   | shift-add iterations, one bit of the multiplier per cycle
// DIV   | restoring division iterations, one quotient bit per cycle
// FIN   | sign correction and HI/LO write, then back to IDLE
module md_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_div_q, op_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] work_hi_q, work_hi_d;
    logic [WIDTH-1:0] work_lo_q, work_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial, div_diff;
    logic [2*WIDTH-1:0] prod_abs, prod_fix;
    logic               accept;

    assign busy   = (state_q != S_IDLE);
    assign stall  = busy | (start & ~flush);
    assign accept = (state_q == S_IDLE) & start & ~flush;
    assign hi     = hi_q;
    assign lo     = lo_q;

    // Operand magnitudes and the per-step multiply/divide arithmetic.
    always_comb begin
        a_mag     = (op[0] && a[WIDTH-1]) ? -a : a;
        b_mag     = (op[0] && b[WIDTH-1]) ? -b : b;
        // Multiplier sits in work_lo and shifts out LSB-first; product grows into work_hi.
        mul_sum   = {1'b0, work_hi_q} + {1'b0, (work_lo_q[0] ? opb_q : {WIDTH{1'b0}})};
        // Partial remainder shifted left by one with the next dividend bit from work_lo.
        div_trial = {work_hi_q, work_lo_q[WIDTH-1]};
        div_diff  = div_trial - {1'b0, opb_q};
        prod_abs  = {work_hi_q, work_lo_q};
        prod_fix  = neg_res_q ? -prod_abs : prod_abs;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_div_d  = op_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        opb_d     = opb_q;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_div_d = op[1];
                    cnt_d    = '0;
                    if (op[1] && (b == '0)) begin
                        // Divide by zero: preload the fixed result, no sign fix-up.
                        state_d   = S_FIN;
                        opb_d     = '0;
                        work_hi_d = a;
                        work_lo_d = '1;
                        neg_res_d = 1'b0;
                        neg_rem_d = 1'b0;
                    end else begin
                        state_d   = op[1] ? S_DIV : S_MUL;
                        opb_d     = b_mag;
                        work_hi_d = '0;
                        work_lo_d = a_mag;
                        neg_res_d = op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem_d = op[0] & a[WIDTH-1];
                    end
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            S_MUL: begin
                work_hi_d = mul_sum[WIDTH:1];
                work_lo_d = {mul_sum[0], work_lo_q[WIDTH-1:1]};
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = S_FIN;
            end
            S_DIV: begin
                if (!div_diff[WIDTH]) begin
                    work_hi_d = div_diff[WIDTH-1:0];
                    work_lo_d = {work_lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    work_hi_d = div_trial[WIDTH-1:0];
                    work_lo_d = {work_lo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = S_FIN;
            end
            default: begin
                state_d = S_IDLE;
                if (op_div_q) begin
                    lo_d = neg_res_q ? -work_lo_q : work_lo_q;
                    hi_d = neg_rem_q ? -work_hi_q : work_hi_q;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
        endcase

        // Abort wins over everything in flight, including the FIN write.
        if (flush && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // State and datapath registers, cleared asynchronously by Rst.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opb_q     <= '0;
            work_hi_q <= '0;
            work_lo_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_div_q  <= op_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            opb_q     <= opb_d;
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: the driver pushes the expected HI/LO and
// completion cycle for every issued operation; a monitor pops and compares
// whenever busy falls.
module tb_md_unit;

    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         flush = 1'b0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic [W-1:0] hi, lo;
    logic         busy, stall;

    md_unit #(.WIDTH(W)) dut (
        .Clk(Clk), .Rst(Rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy), .stall(stall)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           done;
    } exp_t;

    exp_t         sbq[$];
    exp_t         mon_e;
    logic         prev_busy = 1'b0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: plain 64-bit arithmetic on the architectural definitions.
    function automatic void ref_op(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                                   output logic [W-1:0] rh, output logic [W-1:0] rl);
        logic [2*W-1:0] p;
        longint sa, sb, q, r;
        sa = longint'($signed(va));
        sb = longint'($signed(vb));
        p  = '0;
        if (o == 2'd0) p = {{W{1'b0}}, va} * {{W{1'b0}}, vb};
        if (o == 2'd1) p = sa * sb;
        if (!o[1]) begin
            rh = p[2*W-1:W];
            rl = p[W-1:0];
        end else if (vb == '0) begin
            rh = va;
            rl = '1;
        end else if (!o[0]) begin
            rl = va / vb;
            rh = va % vb;
        end else if (va == 32'h8000_0000 && vb == 32'hFFFF_FFFF) begin
            rl = 32'h8000_0000;
            rh = '0;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            rl = q[W-1:0];
            rh = r[W-1:0];
        end
    endfunction

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = '1;
            2: v = 32'h8000_0000;
            3: v = 32'd1;
            4: v = W'($urandom_range(0, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Monitor: a completed (or aborted) operation shows up as busy falling.
    always @(negedge Clk) begin
        if (prev_busy && !busy) begin
            if (sbq.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: busy fell at cycle %0d, expected no completion", cyc);
            end else begin
                mon_e = sbq.pop_front();
                check("result_hi", hi, mon_e.hi);
                check("result_lo", lo, mon_e.lo);
                check("done_cycle", cyc, mon_e.done);
            end
        end
        prev_busy = busy;
    end

    task automatic mt(input bit wh, input bit wl, input logic [W-1:0] v);
        @(negedge Clk);
        hi_we = wh;
        lo_we = wl;
        wdata = v;
        @(posedge Clk);
        #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (wh) m_hi = v;
        if (wl) m_lo = v;
        check("mt_hi", hi, m_hi);
        check("mt_lo", lo, m_lo);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input int flush_at, input int rst_at, input bit lo_we_at_start);
        logic [W-1:0] eh, el;
        int   s;
        bit   finished;
        exp_t e;
        ref_op(o, va, vb, eh, el);
        @(negedge Clk);
        op    = o;
        a     = va;
        b     = vb;
        flush = 1'b0;
        start = 1'b1;
        if (lo_we_at_start) begin
            lo_we = 1'b1;
            wdata = $urandom;
        end
        #1;
        check("stall_request", stall, 1'b1);
        s      = cyc + 1;
        e.done = (o[1] && vb == '0) ? s + 1 : s + W + 1;
        if (flush_at >= 0) begin
            e.hi   = m_hi;
            e.lo   = m_lo;
            e.done = s + flush_at + 1;
        end else if (rst_at >= 0) begin
            e.hi   = '0;
            e.lo   = '0;
            e.done = s + rst_at + 1;
        end else begin
            e.hi = eh;
            e.lo = el;
        end
        sbq.push_back(e);
        m_hi = e.hi;
        m_lo = e.lo;
        @(posedge Clk);
        #1;
        start = 1'b0;
        lo_we = 1'b0;
        check("busy_after_start", busy, 1'b1);
        finished = 1'b0;
        for (int i = 0; i < W + 8 && !finished; i++) begin
            @(negedge Clk);
            if (!busy) begin
                finished = 1'b1;
            end else if (rst_at == cyc - s) begin
                start = 1'b0;
                hi_we = 1'b0;
                lo_we = 1'b0;
                flush = 1'b0;
                #2 Rst = 1'b1;
                #1;
                check("rst_busy", busy, 1'b0);
                check("rst_hi", hi, '0);
                check("rst_lo", lo, '0);
                #1 Rst = 1'b0;
            end else begin
                // Operand, start and MTHI/MTLO noise while busy must have no effect.
                flush = (flush_at == cyc - s);
                a     = $urandom;
                b     = $urandom;
                op    = 2'($urandom);
                start = 1'($urandom);
                hi_we = (cyc - s == 3) | 1'($urandom);
                lo_we = 1'($urandom);
                wdata = $urandom;
            end
        end
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        flush = 1'b0;
        check("op_completes", finished, 1'b1);
    endtask

    initial begin
        // Reset state, and stall = start & ~flush while Rst is high.
        start = 1'b1;
        #1;
        check("reset_hi", hi, '0);
        check("reset_lo", lo, '0);
        check("reset_busy", busy, 1'b0);
        check("reset_stall_start", stall, 1'b1);
        flush = 1'b1;
        #1;
        check("reset_stall_flush", stall, 1'b0);
        start = 1'b0;
        flush = 1'b0;
        #10 Rst = 1'b0;

        mt(1'b1, 1'b0, 32'hAA);
        check("mthi_aa", hi, 32'hAA);

        run_op(2'd1, 32'hFFFF_FFFD, 32'd7, -1, -1, 1'b0);
        check("mult_vec_hi", hi, 32'hFFFF_FFFF);
        check("mult_vec_lo", lo, 32'hFFFF_FFEB);

        run_op(2'd3, 32'hFFFF_FFF9, 32'd2, -1, -1, 1'b0);
        check("div_vec_lo", lo, 32'hFFFF_FFFD);
        check("div_vec_hi", hi, 32'hFFFF_FFFF);

        run_op(2'd2, 32'd100, 32'd7, -1, -1, 1'b0);
        check("divu_vec_lo", lo, 32'd14);
        check("divu_vec_hi", hi, 32'd2);

        run_op(2'd2, 32'd5, 32'd0, -1, -1, 1'b0);
        check("divz_vec_lo", lo, 32'hFFFF_FFFF);
        check("divz_vec_hi", hi, 32'd5);

        run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, 1'b0);
        check("divmin_vec_lo", lo, 32'h8000_0000);
        check("divmin_vec_hi", hi, 32'd0);

        // Flush on iteration 10 of MULTU with 11/22 preloaded.
        mt(1'b1, 1'b1, 32'h11);
        mt(1'b0, 1'b1, 32'h22);
        run_op(2'd0, $urandom, $urandom, 10, -1, 1'b0);
        check("flush_hi", hi, 32'h11);
        check("flush_lo", lo, 32'h22);
        check("flush_busy", busy, 1'b0);

        // lo_we alongside an accepted start is dropped; flushing right away exposes lo.
        run_op(2'd3, $urandom, $urandom, 0, -1, 1'b1);
        check("start_lo_we_lo", lo, 32'h22);

        // Flush during FIN suppresses the result write.
        run_op(2'd1, 32'd1234, 32'd5678, W, -1, 1'b0);

        // start together with flush in IDLE does nothing.
        @(negedge Clk);
        start = 1'b1;
        flush = 1'b1;
        #1;
        check("start_flush_stall", stall, 1'b0);
        @(posedge Clk);
        #1;
        check("start_flush_busy", busy, 1'b0);
        start = 1'b0;
        flush = 1'b0;

        // Reset pulsed mid-DIV, then a clean MULTU.
        run_op(2'd3, 32'd1000, 32'd3, -1, 5, 1'b0);
        run_op(2'd0, 32'd6, 32'd7, -1, -1, 1'b0);
        check("post_rst_lo", lo, 32'd42);
        check("post_rst_hi", hi, 32'd0);

        for (int n = 0; n < 40; n++) begin
            logic [1:0]   ro;
            logic [W-1:0] ra, rb;
            int           fa;
            ro = 2'($urandom);
            ra = pick();
            rb = ($urandom_range(0, 7) == 0) ? '0 : pick();
            fa = ($urandom_range(0, 7) == 0 && !(ro[1] && rb == '0)) ? $urandom_range(0, W) : -1;
            if ($urandom_range(0, 3) == 0) mt(1'($urandom), 1'($urandom), $urandom);
            run_op(ro, ra, rb, fa, -1, 1'b0);
        end

        repeat (3) @(negedge Clk);
        check("scoreboard_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width.
REQ-002 The block SHALL have port Clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-003 The block SHALL have port Rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation.
REQ-005 The block SHALL have port op, input, 2 bits: operation select; 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: a is the multiplicand or dividend, b is the multiplier or divisor.
REQ-007 The block SHALL have port flush, input, 1 bit: abort any in-flight operation.
REQ-008 The block SHALL have ports hi_we and lo_we, input, 1 bit each, and port wdata, input, WIDTH bits: direct writes to HI and LO (MTHI/MTLO).
REQ-009 The block SHALL have ports hi and lo, output, WIDTH bits each: architectural HI and LO registers.
REQ-010 The block SHALL have port busy, output, 1 bit: an operation is in flight.
REQ-011 The block SHALL have port stall, output, 1 bit: hold request to the upstream pipeline registers' write_enable.

Function
REQ-012 The block SHALL implement states IDLE, MUL, DIV and FIN.
REQ-013 In IDLE, start=1 with flush=0 SHALL latch the operand magnitudes, the result signs (signed ops only) and op, clear the iteration counter, and go to MUL or DIV per op[1].
REQ-014 DIV/DIVU with b=0 SHALL go directly to FIN with LO result all ones and HI result = a.
REQ-015 MUL SHALL perform a WIDTH-step shift-add on the magnitudes, one step per cycle, then go to FIN.
REQ-016 DIV SHALL perform a WIDTH-step restoring division on the magnitudes, one step per cycle, then go to FIN.
REQ-017 The iteration counter SHALL be ceil(log2(WIDTH))+1 bits wide and leave MUL/DIV when it reaches WIDTH-1.
REQ-018 FIN SHALL write HI and LO, apply the signs, and return to IDLE.
- MUL: {hi,lo} = 2*WIDTH-bit product, negated if the operand signs differ.
- DIV: lo = quotient, negated if the signs differ; hi = remainder, carrying the sign of a.
REQ-019 Signed DIV of the most negative value by -1 SHALL give lo = the most negative value and hi = 0.
REQ-020 Latency SHALL be WIDTH+2 edges from the start edge to hi/lo valid: WIDTH iterations plus FIN, hi/lo visible after the FIN edge; divide-by-zero takes 2 edges.
REQ-021 busy SHALL be 1 in MUL, DIV and FIN, and 0 in IDLE.
REQ-022 stall SHALL be combinational: busy OR (start AND NOT flush), so the issuing stage holds from the request cycle to the last FIN cycle.
REQ-023 start while busy=1 SHALL be ignored.
REQ-024 In IDLE without start, hi_we SHALL load hi with wdata and lo_we SHALL load lo with wdata, independently.
REQ-025 hi_we/lo_we SHALL be ignored while busy=1 or when an accepted start occurs in the same cycle; start has priority.
REQ-026 flush=1 in any state SHALL return to IDLE next edge with hi/lo unchanged.
- This includes FIN: that edge's result write SHALL be suppressed.
REQ-027 flush=1 together with start in IDLE SHALL not start an operation.
REQ-028 Operands SHALL be sampled only at the start edge; a/b/op changes while busy SHALL have no effect.

Reset
REQ-029 Rst=1 SHALL immediately force state IDLE, counter 0, hi=0, lo=0, busy=0, and all internal datapath registers to 0, without waiting for a clock edge.
REQ-030 stall SHALL equal start AND NOT flush while Rst=1 and after release.
REQ-031 Rst asserted mid-operation SHALL discard the operation.
REQ-032 The first start after Rst release SHALL behave as from a clean IDLE.

Verification
REQ-033 The bench SHALL cover MULT with a=-3, b=7 -> after 34 edges hi=FFFFFFFF, lo=FFFFFFEB; busy high for 33 cycles; stall high from the start cycle.
REQ-034 The bench SHALL cover DIV with a=-7, b=2 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU with a=100, b=7 -> lo=14, hi=2.
REQ-035 The bench SHALL cover DIVU with b=0, a=5 -> 2 edges later lo=FFFFFFFF, hi=5; DIV with a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
REQ-036 The bench SHALL cover flush on iteration 10 of MULTU with hi/lo preloaded with 11/22 -> IDLE next edge, hi=11, lo=22, busy=0.
REQ-037 The bench SHALL cover hi_we with wdata=AA in IDLE -> hi=AA; hi_we during busy -> ignored; start plus lo_we in the same IDLE cycle -> lo_we ignored.
REQ-038 The bench SHALL cover Rst pulsed between clock edges mid-DIV -> busy=0, hi=lo=0 immediately; a following MULTU 6x7 -> lo=42, hi=0.
